// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file and the decode hazard logic.
// REG_ZERO is the hard-wired zero register index.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;
    localparam int DEF_PEND_W = 2;
    localparam int REG_ZERO   = 0;

endpackage

// File: rtl/regfile_pend_ctr.sv
// Saturating up/down pending-write counter for a single register.
// It never wraps: an increment at full or a decrement at zero is ignored.
module regfile_pend_ctr
    import regfile_pkg::*;
#(
    parameter int PEND_W = DEF_PEND_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] count,
    output logic              nonzero,
    output logic              full
);

    logic doInc;
    logic doDec;

    assign full    = &count;
    assign nonzero = |count;
    assign doInc   = inc && !full;
    assign doDec   = dec && nonzero;

    // A simultaneous accepted claim and release cancel out.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (doInc && !doDec) begin
            count <= count + PEND_W'(1);
        end else if (doDec && !doInc) begin
            count <= count - PEND_W'(1);
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-first bypass, async clear and a
// per-register pending-write scoreboard for RAW hazard detection in decode.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD,
    parameter int PEND_W = DEF_PEND_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     wr_release,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     claim_en,
    input  logic [ADDR_W-1:0]        claim_addr,
    output logic                     claim_err,
    output logic                     pend_any
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0]             regs [DEPTH];
    logic [DEPTH-1:0][PEND_W-1:0]  cnt;
    logic [DEPTH-1:0]              cntNonzero;
    logic [DEPTH-1:0]              cntFull;
    logic                          relValid;

    assign relValid = we && wr_release;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
        end else if (we && wr_addr != ZERO_ADDR) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Register zero has no counter, so it can never become busy or saturate.
    assign cnt[0]        = '0;
    assign cntNonzero[0] = 1'b0;
    assign cntFull[0]    = 1'b0;

    for (genvar r = 1; r < DEPTH; r++) begin : gPend
        regfile_pend_ctr #(
            .PEND_W (PEND_W)
        ) uCtr (
            .clock   (clock),
            .reset   (reset),
            .inc     (claim_en && claim_addr == ADDR_W'(r)),
            .dec     (relValid && wr_addr == ADDR_W'(r)),
            .count   (cnt[r]),
            .nonzero (cntNonzero[r]),
            .full    (cntFull[r])
        );
    end

    assign pend_any = |cntNonzero;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            claim_err <= 1'b0;
        end else begin
            claim_err <= claim_en && claim_addr != ZERO_ADDR && cntFull[claim_addr];
        end
    end

    // Reset gating keeps the bypass path from leaking wr_data while clearing.
    for (genvar i = 0; i < NUM_RD; i++) begin : gRead
        logic [ADDR_W-1:0] addr;
        logic              bypass;
        logic              lastRelease;

        assign addr        = rd_addr[i*ADDR_W +: ADDR_W];
        assign bypass      = we && wr_addr == addr;
        assign lastRelease = relValid && wr_addr == addr && cnt[addr] == PEND_W'(1);

        assign rd_data[i*DATA_W +: DATA_W] =
            (reset || addr == ZERO_ADDR) ? '0 :
            bypass                       ? wr_data :
                                           regs[addr];

        assign rd_busy[i] = !reset && cntNonzero[addr] && !lastRelease;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp at NUM_RD=4, DATA_W=64, ADDR_W=4:
// directed vector table, a reset-mid-cycle sequence, then random traffic vs. a model.
module tb_regfile_mp;

    localparam int DW    = 64;
    localparam int AW    = 4;
    localparam int NR    = 4;
    localparam int PW    = 2;
    localparam int DEPTH = 16;
    localparam int CMAX  = 3;
    localparam int RAND_CYCLES = 10000;

    logic              clock;
    logic              reset;
    logic              we;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              wr_release;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_busy;
    logic              claim_en;
    logic [AW-1:0]     claim_addr;
    logic              claim_err;
    logic              pend_any;

    int testsRun;
    int testsFailed;

    logic [DW-1:0] mdlMem [DEPTH];
    int            mdlCnt [DEPTH];
    logic          mdlErr;

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          rel;
        logic          ce;
        logic [AW-1:0] ca;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [NR-1:0] busy;
        logic          err;
        logic          pend;
    } vec_t;

    vec_t vecs [19];

    regfile_mp #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .NUM_RD (NR),
        .PEND_W (PW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .we         (we),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_release (wr_release),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .claim_err  (claim_err),
        .pend_any   (pend_any)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic weV, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                 input logic rel, input logic ce, input logic [AW-1:0] ca,
                                 input logic [NR*AW-1:0] ra);
        we         = weV;
        wr_addr    = wa;
        wr_data    = wd;
        wr_release = rel;
        claim_en   = ce;
        claim_addr = ca;
        rd_addr    = ra;
    endtask

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] portData(input int p);
        return rd_data[p*DW +: DW];
    endfunction

    task automatic clearModel();
        for (int r = 0; r < DEPTH; r++) begin
            mdlMem[r] = '0;
            mdlCnt[r] = 0;
        end
        mdlErr = 1'b0;
    endtask

    // Checks all outputs against the model for the inputs currently applied.
    task automatic checkAgainstModel();
        logic [AW-1:0] a;
        logic [DW-1:0] expD;
        logic          expB;
        logic          expP;
        expP = 1'b0;
        for (int r = 0; r < DEPTH; r++) begin
            if (mdlCnt[r] != 0) expP = 1'b1;
        end
        for (int p = 0; p < NR; p++) begin
            a = rd_addr[p*AW +: AW];
            if (reset || a == '0)          expD = '0;
            else if (we && wr_addr == a)   expD = wr_data;
            else                           expD = mdlMem[a];
            expB = !reset && mdlCnt[a] != 0 &&
                   !(we && wr_release && wr_addr == a && mdlCnt[a] == 1);
            checkOutput($sformatf("rand rd_data[%0d]", p), portData(p), expD);
            checkOutput($sformatf("rand rd_busy[%0d]", p), 64'(rd_busy[p]), 64'(expB));
        end
        checkOutput("rand claim_err", 64'(claim_err), 64'(reset ? 1'b0 : mdlErr));
        checkOutput("rand pend_any", 64'(pend_any), 64'(expP));
    endtask

    // Applies one clock edge worth of the specified register-file rules.
    task automatic updateModel();
        logic claimHit;
        logic incOk;
        logic decOk;
        if (reset) begin
            clearModel();
            return;
        end
        claimHit = claim_en && claim_addr != '0;
        incOk    = claimHit && mdlCnt[claim_addr] < CMAX;
        decOk    = we && wr_release && wr_addr != '0 && mdlCnt[wr_addr] > 0;
        mdlErr   = claimHit && mdlCnt[claim_addr] == CMAX;
        if (incOk) mdlCnt[claim_addr] = mdlCnt[claim_addr] + 1;
        if (decOk) mdlCnt[wr_addr]    = mdlCnt[wr_addr] - 1;
        if (we && wr_addr != '0) mdlMem[wr_addr] = wr_data;
    endtask

    task automatic randomCycle();
        logic [AW-1:0] ra;
        @(negedge clock);
        reset      = ($urandom_range(0, 499) == 0);
        we         = 1'($urandom_range(0, 1));
        wr_addr    = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
        wr_data    = {$urandom, $urandom};
        wr_release = 1'($urandom_range(0, 1));
        claim_en   = 1'($urandom_range(0, 1));
        claim_addr = 4'($urandom_range(0, 5));
        for (int p = 0; p < NR; p++) begin
            ra = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
            rd_addr[p*AW +: AW] = ra;
        end
        if (reset) clearModel();
        #1;
        checkAgainstModel();
        @(posedge clock);
        updateModel();
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        clearModel();

        vecs[0]  = '{1'b1, 4'd7, 64'h12345678, 1'b0, 1'b0, 4'd0, 4'd7, 4'd7, 64'h12345678, 64'h12345678, 4'b0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 4'd0, 64'h0,        1'b0, 1'b0, 4'd0, 4'd7, 4'd7, 64'h12345678, 64'h12345678, 4'b0000, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 4'd0, '1,           1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 64'h0,        64'h0,        4'b0000, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 4'd0, 64'h0,        1'b0, 1'b1, 4'd0, 4'd0, 4'd7, 64'h0,        64'h12345678, 4'b0000, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 4'd0, 64'h0,        1'b0, 1'b1, 4'd0, 4'd0, 4'd7, 64'h0,        64'h12345678, 4'b0000, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 4'd0, 64'h0,        1'b0, 1'b1, 4'd0, 4'd0, 4'd7, 64'h0,        64'h12345678, 4'b0000, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 4'd0, 64'h0,        1'b0, 1'b1, 4'd3, 4'd3, 4'd0, 64'h0,        64'h0,        4'b0000, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 4'd0, 64'h0,        1'b0, 1'b1, 4'd3, 4'd3, 4'd3, 64'h0,        64'h0,        4'b0011, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 4'd3, 64'h5,        1'b1, 1'b0, 4'd0, 4'd3, 4'd3, 64'h5,        64'h5,        4'b0011, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 4'd3, 64'h9,        1'b1, 1'b0, 4'd0, 4'd3, 4'd3, 64'h9,        64'h9,        4'b0000, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 4'd0, 64'h0,        1'b0, 1'b0, 4'd0, 4'd3, 4'd3, 64'h9,        64'h9,        4'b0000, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 4'd3, 64'hA,        1'b1, 1'b0, 4'd0, 4'd3, 4'd0, 64'hA,        64'h0,        4'b0000, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 4'd0, 64'h0,        1'b0, 1'b1, 4'd4, 4'd4, 4'd3, 64'h0,        64'hA,        4'b0000, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 4'd0, 64'h0,        1'b0, 1'b1, 4'd4, 4'd4, 4'd3, 64'h0,        64'hA,        4'b0001, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 4'd0, 64'h0,        1'b0, 1'b1, 4'd4, 4'd4, 4'd3, 64'h0,        64'hA,        4'b0001, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 4'd0, 64'h0,        1'b0, 1'b1, 4'd4, 4'd4, 4'd3, 64'h0,        64'hA,        4'b0001, 1'b0, 1'b1};
        vecs[16] = '{1'b1, 4'd4, 64'h44,       1'b1, 1'b0, 4'd0, 4'd4, 4'd4, 64'h44,       64'h44,       4'b0011, 1'b1, 1'b1};
        vecs[17] = '{1'b1, 4'd4, 64'h55,       1'b1, 1'b1, 4'd4, 4'd4, 4'd4, 64'h55,       64'h55,       4'b0011, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 4'd0, 64'h0,        1'b0, 1'b0, 4'd0, 4'd4, 4'd4, 64'h55,       64'h55,       4'b0011, 1'b0, 1'b1};

        // Reset state, with a live bypass candidate that must stay hidden.
        reset = 1'b1;
        applyStimulus(1'b1, 4'd7, 64'hABC, 1'b0, 1'b0, 4'd0, {4'd0, 4'd0, 4'd5, 4'd7});
        @(negedge clock);
        #1;
        checkOutput("reset rd_data[0]", portData(0), 64'h0);
        checkOutput("reset rd_data[1]", portData(1), 64'h0);
        checkOutput("reset rd_busy", 64'(rd_busy), 64'h0);
        checkOutput("reset pend_any", 64'(pend_any), 64'h0);
        checkOutput("reset claim_err", 64'(claim_err), 64'h0);
        @(negedge clock);
        reset = 1'b0;

        for (int v = 0; v < 19; v++) begin
            applyStimulus(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].rel, vecs[v].ce, vecs[v].ca,
                          {4'd0, 4'd0, vecs[v].ra1, vecs[v].ra0});
            #1;
            checkOutput($sformatf("vec%0d rd_data[0]", v), portData(0), vecs[v].d0);
            checkOutput($sformatf("vec%0d rd_data[1]", v), portData(1), vecs[v].d1);
            checkOutput($sformatf("vec%0d rd_busy", v), 64'(rd_busy), 64'(vecs[v].busy));
            checkOutput($sformatf("vec%0d claim_err", v), 64'(claim_err), 64'(vecs[v].err));
            checkOutput($sformatf("vec%0d pend_any", v), 64'(pend_any), 64'(vecs[v].pend));
            @(negedge clock);
        end

        // Reset asserted mid-cycle with r4 still pending and a write to r5 in flight.
        applyStimulus(1'b1, 4'd5, 64'hDEADBEEF, 1'b0, 1'b0, 4'd0, {4'd0, 4'd0, 4'd4, 4'd5});
        #1;
        checkOutput("mid bypass r5", portData(0), 64'hDEADBEEF);
        @(negedge clock);
        applyStimulus(1'b0, 4'd0, 64'h0, 1'b0, 1'b0, 4'd0, {4'd0, 4'd0, 4'd4, 4'd5});
        #1;
        checkOutput("mid stored r5", portData(0), 64'hDEADBEEF);
        checkOutput("mid busy r4", 64'(rd_busy[1]), 64'h1);
        #1;
        reset = 1'b1;
        applyStimulus(1'b1, 4'd5, 64'h1234, 1'b1, 1'b1, 4'd4, {4'd0, 4'd0, 4'd4, 4'd5});
        #1;
        checkOutput("mid reset r5", portData(0), 64'h0);
        checkOutput("mid reset r4", portData(1), 64'h0);
        checkOutput("mid reset busy", 64'(rd_busy), 64'h0);
        checkOutput("mid reset pend_any", 64'(pend_any), 64'h0);
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(1'b0, 4'd0, 64'h0, 1'b0, 1'b0, 4'd0, {4'd0, 4'd0, 4'd4, 4'd5});
        #1;
        checkOutput("post reset r5", portData(0), 64'h0);
        checkOutput("post reset busy", 64'(rd_busy), 64'h0);
        checkOutput("post reset pend_any", 64'(pend_any), 64'h0);
        checkOutput("post reset claim_err", 64'(claim_err), 64'h0);

        clearModel();
        for (int c = 0; c < RAND_CYCLES; c++) begin
            randomCycle();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
